// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C register slave.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } i2c_state_t;

    localparam logic       I2C_BIT_ACK = 1'b0;
    localparam logic       I2C_RW_READ = 1'b1;
    localparam logic [6:0] I2C_GENCALL = 7'h00;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus glitch filter for one I2C pad line.
// Emits one-cycle rise/fall flags aligned with the filtered level change.
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic line,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= 2'b11;
            cnt  <= '0;
            line <= 1'b1;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[0], line_in};
            rise <= 1'b0;
            fall <= 1'b0;
            // Any sample agreeing with the current level restarts the run.
            if (sync[1] == line) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT_LEN - 1)) begin
                cnt  <= '0;
                line <= sync[1];
                rise <= sync[1];
                fall <= ~sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave mapping bus transfers onto a pointer-based register port.
// All pad activity is oversampled on clk_50M; SCL is never driven.
module i2c_slave_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         REG_AW   = 4,
    parameter int         FILT_LEN = 3,
    parameter int         TX_HOLD  = 8
) (
    input  logic              clk_50M,
    input  logic              rst_n,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [REG_AW-1:0] reg_addr,
    output logic              reg_wr,
    output logic [7:0]        reg_wdata,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              xfer_done
);

    import i2c_pkg::*;

    localparam int HW = $clog2(TX_HOLD + 1);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl (
        .clk(clk_50M), .rst_n(rst_n), .line_in(scl_in),
        .line(scl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda (
        .clk(clk_50M), .rst_n(rst_n), .line_in(sda_in),
        .line(sda), .rise(sda_rise), .fall(sda_fall)
    );

    i2c_state_t    state, state_nxt;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [7:0]    shifted;
    logic          rw;
    logic [HW-1:0] hold_cnt;
    logic          oe_pend;
    logic          rd_load;
    logic          start, stop, last_bit, data_st, ack_st, oe_val;
    logic          wr_go, rd_go, ptr_load, inc, nack, match;

    // An SDA edge coincident with the SCL rise still counts as SCL high.
    assign start    = sda_fall & (scl | scl_rise);
    assign stop     = sda_rise & (scl | scl_rise);
    assign last_bit = (bit_cnt == 4'd7);
    assign shifted  = {shreg[6:0], sda};
    assign data_st  = state inside {ADDR, PTR, WDATA, RDATA};
    assign ack_st   = state inside {ADDR_ACK, PTR_ACK, WDATA_ACK};
    assign oe_val   = ack_st | ((state == RDATA) & ~shreg[7]);

    always_ff @(posedge clk_50M) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_go     = 1'b0;
        rd_go     = 1'b0;
        ptr_load  = 1'b0;
        inc       = 1'b0;
        nack      = 1'b0;
        match     = 1'b0;
        if (stop) begin
            state_nxt = IDLE;
        end else if (start) begin
            state_nxt = ADDR;
        end else if (scl_rise) begin
            unique case (state)
                ADDR: if (last_bit) begin
                    if (shifted[7:1] == DEV_ADDR && DEV_ADDR != I2C_GENCALL) begin
                        state_nxt = ADDR_ACK;
                        match     = 1'b1;
                    end else begin
                        state_nxt = IGNORE;
                    end
                end
                ADDR_ACK: begin
                    if (rw == I2C_RW_READ) begin
                        state_nxt = RDATA;
                        rd_go     = 1'b1;
                    end else begin
                        state_nxt = PTR;
                    end
                end
                PTR: if (last_bit) begin
                    state_nxt = PTR_ACK;
                    ptr_load  = 1'b1;
                end
                PTR_ACK:   state_nxt = WDATA;
                WDATA: if (last_bit) begin
                    state_nxt = WDATA_ACK;
                    wr_go     = 1'b1;
                end
                WDATA_ACK: state_nxt = WDATA;
                RDATA: if (last_bit) state_nxt = RDATA_ACK;
                RDATA_ACK: begin
                    if (sda == I2C_BIT_ACK) begin
                        state_nxt = RDATA;
                        rd_go     = 1'b1;
                        inc       = 1'b1;
                    end else begin
                        state_nxt = IGNORE;
                        nack      = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            sda_oe    <= 1'b0;
            reg_addr  <= '0;
            reg_wr    <= 1'b0;
            reg_wdata <= '0;
            reg_rd    <= 1'b0;
            busy      <= 1'b0;
            xfer_done <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rw        <= 1'b0;
            hold_cnt  <= '0;
            oe_pend   <= 1'b0;
            rd_load   <= 1'b0;
        end else begin
            reg_wr    <= wr_go;
            reg_rd    <= rd_go;
            rd_load   <= reg_rd;
            xfer_done <= 1'b0;
            if (wr_go) reg_wdata <= shifted;
            if (ptr_load)          reg_addr <= shifted[REG_AW-1:0];
            else if (inc || reg_wr) reg_addr <= reg_addr + 1'b1;
            if (match) rw <= shifted[0];
            if (start || stop) begin
                bit_cnt   <= '0;
                hold_cnt  <= '0;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                xfer_done <= stop & busy;
            end else begin
                if (match) busy <= 1'b1;
                if (scl_rise && data_st) begin
                    shreg   <= shifted;
                    bit_cnt <= bit_cnt + 1'b1;
                end else if (scl_rise) begin
                    bit_cnt <= '0;
                end
                // SDA only changes a fixed hold time after SCL is seen low.
                if (scl_fall) begin
                    hold_cnt <= HW'(TX_HOLD);
                    oe_pend  <= oe_val;
                end else if (hold_cnt != '0) begin
                    hold_cnt <= hold_cnt - 1'b1;
                    if (hold_cnt == HW'(1)) sda_oe <= oe_pend;
                end
                if (nack) sda_oe <= 1'b0;
            end
            if (rd_load) shreg <= reg_rdata;
        end
    end

endmodule
